cpu_run_ctrl: RTL and testbench

- Parametrised run controller that replaces fixed-delay CPU simulation runs (hard-coded reset, fixed-time finish).
- Sequences the CPU reset, counts executed cycles and detects program halt (jump-to-self: PC stable for HALT_STABLE cycles).
- Enforces a cycle-budget timeout and reports done/halted/timeout status.
- Synthesisable; sits beside `cpu` in benches and FPGA bring-up tops.

---
 rtl/cpu_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU benches: sequences CPU reset, counts RUN cycles, detects jump-to-self halt, enforces a cycle budget.
// Optional signature check (pass output, EXPECT_PC parameter) is enabled by defining CPU_RUN_CTRL_SIG_EN.
module cpu_run_ctrl #(
  parameter int PC_W         = 8,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 4,
  parameter int HALT_STABLE  = 2,
  parameter int MAX_CYCLES   = 15
`ifdef CPU_RUN_CTRL_SIG_EN
  ,
  parameter logic [PC_W-1:0] EXPECT_PC = '0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  output logic             dut_rst_n,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [PC_W-1:0]  halt_pc
`ifdef CPU_RUN_CTRL_SIG_EN
  ,
  output logic             pass
`endif
);

  localparam int ST_W = (HALT_STABLE < 1) ? 1 : $clog2(HALT_STABLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t           state_q;
  logic [7:0]       rst_cnt_q;
  logic [ST_W-1:0]  stable_cnt_q;
  logic [ST_W-1:0]  stable_cnt_d;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] cycles_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  halt_pc_q;
  logic             dut_rst_n_q;
  logic             running_q;
  logic             done_q;
  logic             halted_q;
  logic             timeout_q;
  logic             halt_now;
  logic             timeout_now;
`ifdef CPU_RUN_CTRL_SIG_EN
  logic             pass_q;
`endif

  // Next-cycle counter values for RUN; halt has priority over timeout.
  always_comb begin
    cycles_d     = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
    stable_cnt_d = '0;
    if (pc == pc_q) begin
      stable_cnt_d = (stable_cnt_q == '1) ? stable_cnt_q : stable_cnt_q + 1'b1;
    end
    halt_now    = (stable_cnt_d >= ST_W'(HALT_STABLE));
    timeout_now = !halt_now && (cycles_d == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      stable_cnt_q <= '0;
      cycles_q     <= '0;
      pc_q         <= '0;
      halt_pc_q    <= '0;
      dut_rst_n_q  <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef CPU_RUN_CTRL_SIG_EN
      pass_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_HALTED, S_TIMEOUT: begin
          if (start) begin
            state_q     <= S_RST;
            rst_cnt_q   <= '0;
            cycles_q    <= '0;
            halt_pc_q   <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            dut_rst_n_q <= 1'b0;
`ifdef CPU_RUN_CTRL_SIG_EN
            pass_q      <= 1'b0;
`endif
          end
        end
        S_RST: begin
          if (rst_cnt_q == 8'(RESET_CYCLES - 1)) begin
            state_q      <= S_RUN;
            dut_rst_n_q  <= 1'b1;
            running_q    <= 1'b1;
            pc_q         <= pc;
            stable_cnt_q <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          cycles_q     <= cycles_d;
          stable_cnt_q <= stable_cnt_d;
          pc_q         <= pc;
          if (halt_now) begin
            // CPU is left out of reset so it keeps spinning on its halt loop.
            state_q   <= S_HALTED;
            halted_q  <= 1'b1;
            halt_pc_q <= pc;
            running_q <= 1'b0;
            done_q    <= 1'b1;
`ifdef CPU_RUN_CTRL_SIG_EN
            pass_q    <= (pc == EXPECT_PC);
`endif
          end else if (timeout_now) begin
            state_q     <= S_TIMEOUT;
            timeout_q   <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b1;
            dut_rst_n_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CPU_RUN_CTRL_SIG_EN
  assign pass = pass_q;
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && state_q == S_RUN && (halt_now || timeout_now)) begin
      $display("[cpu_run_ctrl] %s cycles=%0d halt_pc=%0d",
               halt_now ? "HALTED" : "TIMEOUT", cycles_d, halt_now ? pc : '0);
    end
  end
`endif
`endif

  assign dut_rst_n = dut_rst_n_q;
  assign running   = running_q;
  assign done      = done_q;
  assign halted    = halted_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;
  assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny CPU model drives pc (counts up out of reset, sticks at hold_pc).
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  pc;
  logic        dut_rst_n;
  logic        running;
  logic        done;
  logic        halted;
  logic        timeout;
  logic [15:0] cycles;
  logic [7:0]  halt_pc;
`ifdef CPU_RUN_CTRL_SIG_EN
  logic        pass;
`endif

  logic [7:0] hold_pc;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rst_len;
  int         run_len;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W(8), .CNT_W(16), .RESET_CYCLES(4), .HALT_STABLE(2), .MAX_CYCLES(15)
`ifdef CPU_RUN_CTRL_SIG_EN
    , .EXPECT_PC(8'd5)
`endif
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pc        (pc),
    .dut_rst_n (dut_rst_n),
    .running   (running),
    .done      (done),
    .halted    (halted),
    .timeout   (timeout),
    .cycles    (cycles),
    .halt_pc   (halt_pc)
`ifdef CPU_RUN_CTRL_SIG_EN
    , .pass    (pass)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; the CPU model follows the dut_rst_n value seen during the cycle.
  task automatic step();
    logic rs;
    rs = dut_rst_n;
    @(posedge clk);
    #1;
    if (!rs) pc = 8'd0;
    else if (pc != hold_pc) pc = pc + 8'd1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Measures CPU-reset length and RUN length (bounded); RUN must keep dut_rst_n/running high.
  task automatic run_to_done();
    logic hi_ok;
    hi_ok   = 1'b1;
    rst_len = 0;
    run_len = 0;
    while (!dut_rst_n && rst_len < 50) begin
      step();
      rst_len++;
    end
    while (!done && run_len < 100) begin
      if (!dut_rst_n || !running) hi_ok = 1'b0;
      step();
      run_len++;
    end
    check("run_high", 32'(hi_ok), 32'd1);
    $display("[TB] run hold_pc=%0d rst_len=%0d run_len=%0d halted=%0d timeout=%0d cycles=%0d halt_pc=%0d",
             hold_pc, rst_len, run_len, halted, timeout, cycles, halt_pc);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    pc      = 8'd0;
    hold_pc = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dut_rst_n", 32'(dut_rst_n), 0);
    check("rst_running",   32'(running),   0);
    check("rst_done",      32'(done),      0);
    check("rst_halted",    32'(halted),    0);
    check("rst_timeout",   32'(timeout),   0);
    check("rst_cycles",    32'(cycles),    0);
    check("rst_halt_pc",   32'(halt_pc),   0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_dut_rst_n", 32'(dut_rst_n), 0);
    check("idle_done",      32'(done),      0);

    // Free-running pc: budget exhausted.
    hold_pc = 8'hFF;
    do_start();
    run_to_done();
    check("to_rst_len",   32'(rst_len),   4);
    check("to_run_len",   32'(run_len),   15);
    check("to_timeout",   32'(timeout),   1);
    check("to_halted",    32'(halted),    0);
    check("to_done",      32'(done),      1);
    check("to_cycles",    32'(cycles),    15);
    check("to_dut_rst_n", 32'(dut_rst_n), 0);
    check("to_running",   32'(running),   0);
`ifdef CPU_RUN_CTRL_SIG_EN
    check("to_pass",      32'(pass),      0);
`endif

    // pc sticks at 5: halt after two stable cycles.
    hold_pc = 8'd5;
    do_start();
    check("h5_cleared_timeout", 32'(timeout), 0);
    run_to_done();
    check("h5_rst_len",   32'(rst_len),   4);
    check("h5_halted",    32'(halted),    1);
    check("h5_timeout",   32'(timeout),   0);
    check("h5_halt_pc",   32'(halt_pc),   5);
    check("h5_cycles",    32'(cycles),    8);
    check("h5_dut_rst_n", 32'(dut_rst_n), 1);
`ifdef CPU_RUN_CTRL_SIG_EN
    check("h5_pass",      32'(pass),      1);
`endif
    repeat (3) step();
    check("h5_hold_dut_rst_n", 32'(dut_rst_n), 1);
    check("h5_hold_cycles",    32'(cycles),    8);
    check("h5_hold_done",      32'(done),      1);

    // Restart from HALTED; halt at 12 coincides with the 15th RUN cycle.
    hold_pc = 8'd12;
    do_start();
    check("re_cycles",    32'(cycles),    0);
    check("re_halted",    32'(halted),    0);
    check("re_halt_pc",   32'(halt_pc),   0);
    check("re_done",      32'(done),      0);
    check("re_dut_rst_n", 32'(dut_rst_n), 0);
    run_to_done();
    check("co_rst_len",   32'(rst_len),   4);
    check("co_run_len",   32'(run_len),   15);
    check("co_halted",    32'(halted),    1);
    check("co_timeout",   32'(timeout),   0);
    check("co_cycles",    32'(cycles),    15);
    check("co_halt_pc",   32'(halt_pc),   12);

`ifdef CPU_RUN_CTRL_SIG_EN
    hold_pc = 8'd6;
    do_start();
    run_to_done();
    check("h6_halted",  32'(halted),  1);
    check("h6_halt_pc", 32'(halt_pc), 6);
    check("h6_cycles",  32'(cycles),  9);
    check("h6_pass",    32'(pass),    0);
`endif

    // Mid-run asynchronous reset; start during RUN is ignored.
    hold_pc = 8'hFF;
    do_start();
    for (int i = 0; i < 4 && !dut_rst_n; i++) step();
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_running", 32'(running), 1);
    check("ign_cycles",  32'(cycles),  4);
    repeat (3) step();
    check("mid_cycles", 32'(cycles), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dut_rst_n", 32'(dut_rst_n), 0);
    check("ar_running",   32'(running),   0);
    check("ar_done",      32'(done),      0);
    check("ar_cycles",    32'(cycles),    0);
    check("ar_halted",    32'(halted),    0);
    check("ar_timeout",   32'(timeout),   0);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    check("post_dut_rst_n", 32'(dut_rst_n), 0);
    check("post_running",   32'(running),   0);
    check("post_cycles",    32'(cycles),    0);
    do_start();
    run_to_done();
    check("post_run_len", 32'(run_len), 15);
    check("post_timeout", 32'(timeout), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
